trg_mon_frame_seq: RTL

//  Downstream consumer of the trigger monitor-register read mux. On a start request it sweeps
//  the monitor address range, drives rd/rd_addr into the mux and captures each mon_data word.

---
 rtl/trg_mon_pkg.sv | 25 ++
 rtl/trg_mon_word_out.sv | 47 ++++
 rtl/trg_mon_frame_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/trg_mon_pkg.sv
// Shared types and defaults for the trigger monitor frame sequencer:
// FSM states, header sync word and default sweep range.
package trg_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_FCNT,
        ST_ISSUE,
        ST_WAIT,
        ST_DATA,
        ST_CSUM
    } trg_mon_state_e;

    localparam logic [15:0] HEADER_WORD_DEF = 16'hEB90;
    localparam logic [7:0]  ADDR_FIRST_DEF  = 8'd25;
    localparam logic [7:0]  ADDR_LAST_DEF   = 8'd62;

    // Widened before subtracting so a full 0..FF sweep reports 256 rather than 0.
    function automatic logic [15:0] sweepLength(input logic [7:0] first, input logic [7:0] last);
        return 16'(last) - 16'(first) + 16'd1;
    endfunction

endpackage

// File: rtl/trg_mon_word_out.sv
// Valid/ready output holding register: takes a word plus last flag when empty
// or while its current word is being accepted, and holds it stable otherwise.
module trg_mon_word_out
    import trg_mon_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic        i_last,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_data,
    output logic        o_last
);

    logic        r_valid;
    logic [15:0] r_data;
    logic        r_last;
    logic        w_xfer;
    logic        w_canLoad;

    assign w_xfer    = r_valid & i_ready;
    assign w_canLoad = ~r_valid | w_xfer;

    // Data and last are cleared when the register empties so last never lingers on an idle bus.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load && w_canLoad) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/trg_mon_frame_seq.sv
// Sweeps the trigger monitor registers on request and emits one framed packet
// (header, length, [frame count], data, checksum). Define TRG_MON_FRMCNT_EN to insert the frame counter word.
module trg_mon_frame_seq
    import trg_mon_pkg::*;
#(
    parameter logic [7:0]  ADDR_FIRST  = ADDR_FIRST_DEF,
    parameter logic [7:0]  ADDR_LAST   = ADDR_LAST_DEF,
    parameter int          RD_LAT      = 1,
    parameter logic [15:0] HEADER_WORD = HEADER_WORD_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    output logic        rd_out,
    output logic [7:0]  rd_addr_out,
    input  logic [15:0] mon_data_in,
    output logic        out_valid_out,
    output logic [15:0] out_data_out,
    output logic        out_last_out,
    input  logic        out_ready_in,
    output logic        busy_out,
    output logic        start_drop_out
);

    localparam logic [15:0] N_WORDS   = sweepLength(ADDR_FIRST, ADDR_LAST);
    localparam logic [2:0]  WAIT_LAST = 3'(RD_LAT - 1);

    trg_mon_state_e r_state;
    trg_mon_state_e w_nextState;

    logic [7:0]  r_addr;
    logic [2:0]  r_waitCnt;
    logic [15:0] r_csum;
    logic        r_startDrop;

    logic        w_outValid;
    logic        w_xfer;
    logic        w_busy;
    logic        w_lastAddr;
    logic        w_load;
    logic [15:0] w_loadData;
    logic        w_loadLast;
    logic        w_addSum;

`ifdef TRG_MON_FRMCNT_EN
    logic [15:0] r_frameCnt;
`endif

    assign w_xfer     = w_outValid & out_ready_in;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_lastAddr = (r_addr == ADDR_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Every word except header and checksum is flagged for the running sum as it is loaded.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadData  = '0;
        w_loadLast  = 1'b0;
        w_addSum    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_nextState = ST_HDR;
                    w_load      = 1'b1;
                    w_loadData  = HEADER_WORD;
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    w_nextState = ST_LEN;
                    w_load      = 1'b1;
                    w_loadData  = N_WORDS;
                    w_addSum    = 1'b1;
                end
            end
            ST_LEN: begin
                if (w_xfer) begin
`ifdef TRG_MON_FRMCNT_EN
                    w_nextState = ST_FCNT;
                    w_load      = 1'b1;
                    w_loadData  = r_frameCnt;
                    w_addSum    = 1'b1;
`else
                    w_nextState = ST_ISSUE;
`endif
                end
            end
            ST_FCNT: begin
                if (w_xfer) begin
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = ST_DATA;
                    w_load      = 1'b1;
                    w_loadData  = mon_data_in;
                    w_addSum    = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    if (w_lastAddr) begin
                        w_nextState = ST_CSUM;
                        w_load      = 1'b1;
                        w_loadData  = r_csum;
                        w_loadLast  = 1'b1;
                    end else begin
                        w_nextState = ST_ISSUE;
                    end
                end
            end
            ST_CSUM: begin
                if (w_xfer) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_addr      <= '0;
            r_waitCnt   <= '0;
            r_csum      <= '0;
            r_startDrop <= 1'b0;
        end else begin
            r_startDrop <= start_in & w_busy;
            if (r_state == ST_IDLE && start_in) begin
                r_csum <= '0;
            end else if (w_addSum) begin
                r_csum <= r_csum + w_loadData;
            end
            // Termination is by compare against ADDR_LAST, so the increment never has to wrap.
            if ((r_state == ST_LEN || r_state == ST_FCNT) && w_nextState == ST_ISSUE) begin
                r_addr <= ADDR_FIRST;
            end else if (r_state == ST_DATA && w_xfer && !w_lastAddr) begin
                r_addr <= r_addr + 8'd1;
            end
            if (r_state == ST_ISSUE) begin
                r_waitCnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt + 3'd1;
            end
        end
    end

`ifdef TRG_MON_FRMCNT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_frameCnt <= '0;
        end else if (r_state == ST_CSUM && w_xfer) begin
            r_frameCnt <= r_frameCnt + 16'd1;
        end
    end
`endif

    trg_mon_word_out u_wordOut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_load  (w_load),
        .i_data  (w_loadData),
        .i_last  (w_loadLast),
        .i_ready (out_ready_in),
        .o_valid (w_outValid),
        .o_data  (out_data_out),
        .o_last  (out_last_out)
    );

    assign out_valid_out  = w_outValid;
    assign busy_out       = w_busy;
    assign start_drop_out = r_startDrop;
    assign rd_addr_out    = r_addr;
    assign rd_out         = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                            ((r_state == ST_DATA) && !w_lastAddr);

endmodule
